// File: rtl/spram_ctrl_pkg.sv
// spram_ctrl_pkg: shared state encodings and buffer depth for the SPRAM access controller
package spram_ctrl_pkg;
  typedef enum logic {ST_IDLE, ST_BURST} state_t;
  localparam int RSP_DEPTH = 2;
endpackage

// File: rtl/sync_fifo2.sv
// sync_fifo2: two-entry synchronous FIFO with combinational head output
module sync_fifo2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);
  logic [width-1:0] r_mem [2];
  logic             r_wp, r_rp;
  logic [1:0]       r_cnt;
  logic             w_do_push, w_do_pop;
  assign full      = r_cnt == 2'd2;
  assign empty     = r_cnt == 2'd0;
  assign count     = r_cnt;
  assign dout      = r_mem[r_rp];
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then
  assign w_do_push = push & (!full | pop);
  assign w_do_pop  = pop & !empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= !r_wp;
      end
      if (w_do_pop) r_rp <= !r_rp;
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
endmodule

// File: rtl/spram_access_ctrl.sv
// spram_access_ctrl: single-word writes and credit-limited burst reads to a 1-cycle-latency SPRAM
module spram_access_ctrl
  import spram_ctrl_pkg::*;
#(
  parameter int aw = 12,
  parameter int dw = 32,
  parameter int lw = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [aw-1:0] cmd_addr,
  input  logic [lw-1:0] cmd_len,
  input  logic [dw-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [dw-1:0] rsp_data,
  output logic          rsp_last,
  output logic          busy,
  output logic          mem_re,
  output logic          mem_we,
  output logic [aw-1:0] mem_addr,
  output logic [dw-1:0] mem_data,
  input  logic [dw-1:0] mem_q
);
  state_t        r_state, w_next;
  logic [aw-1:0] r_addr;
  logic [lw-1:0] r_rem;
  logic          r_inflight, r_tag_last;
  logic          w_wr, w_rd, w_pop, w_issue, w_full, w_empty;
  logic [1:0]    w_cnt;
  logic [2:0]    w_credit;
  logic [dw:0]   w_head;
  assign cmd_ready = rst_n & (r_state == ST_IDLE) & !r_inflight;
  assign w_wr      = cmd_valid & cmd_ready & cmd_we;
  assign w_rd      = cmd_valid & cmd_ready & !cmd_we;
  assign w_pop     = rsp_valid & rsp_ready;
  // Outstanding words (buffered plus in the RAM pipe) after this cycle's pop must leave a free slot
  assign w_credit  = {1'b0, w_cnt} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue   = (r_state == ST_BURST) & (w_credit < 3'(RSP_DEPTH));
  assign mem_re    = w_issue;
  assign mem_we    = w_wr;
  assign mem_addr  = w_issue ? r_addr : w_wr ? cmd_addr : '0;
  assign mem_data  = w_wr ? cmd_wdata : '0;
  assign rsp_valid = !w_empty;
  assign rsp_data  = w_head[dw-1:0];
  assign rsp_last  = w_head[dw];
  assign busy      = (r_state != ST_IDLE) | r_inflight | !w_empty;
  always_comb
    w_next = w_rd ? ST_BURST : (w_issue && r_rem == '0) ? ST_IDLE : r_state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
      r_tag_last <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_rd) begin
        r_addr     <= cmd_addr;
        r_rem      <= cmd_len;
        r_tag_last <= 1'b0;
      end else if (w_issue) begin
        r_addr     <= r_addr + aw'(1);
        r_rem      <= r_rem - lw'(1);
        r_tag_last <= r_rem == '0;
      end
    end
  sync_fifo2 #(.width(dw + 1)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   ({r_tag_last, mem_q}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(r_inflight && w_full && !w_pop));
endmodule

// File: tb/tb_spram_access_ctrl.sv
// tb_spram_access_ctrl: scoreboard bench for spram_access_ctrl with a behavioural SPRAM model
module tb_spram_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_last, busy;
  logic [31:0] rsp_data;
  logic        mem_re, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_data, mem_q;

  logic [31:0] ram [4096];
  logic [31:0] ref_mem [4096];
  logic [32:0] exp_q [$];
  int          re_addrs [$];
  int          re_cyc [$];
  int          beat_cyc [$];
  int          cyc = 0, n_re = 0, n_pop = 0;
  int          n_checks = 0, n_fail = 0;

  spram_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last), .busy(busy),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    if (mem_re) mem_q <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      n_re = 0;
      n_pop = 0;
    end else begin
      n_checks++;
      if ((mem_re & mem_we) !== 1'b0) begin
        n_fail++;
        $display("FAIL re_we_overlap: mem_re=%b mem_we=%b, required not both 1", mem_re, mem_we);
      end
      if (mem_re) begin
        n_re++;
        re_addrs.push_back(int'(mem_addr));
        re_cyc.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
        logic [32:0] e;
        n_pop++;
        beat_cyc.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got last=%b data=%h, required no beat", rsp_last, rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_last, rsp_data} !== e) begin
            n_fail++;
            $display("FAIL beat_data: got last=%b data=%h, required last=%b data=%h",
                     rsp_last, rsp_data, e[32], e[31:0]);
          end
        end
      end
      n_checks++;
      if (n_re - n_pop > 2) begin
        n_fail++;
        $display("FAIL credit: outstanding=%0d, required <= 2", n_re - n_pop);
      end
    end
  end

  task automatic clear_logs();
    re_addrs.delete();
    re_cyc.delete();
    beat_cyc.delete();
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, output int acc);
    int t = 0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_len = '0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 200) break;
      @(posedge clk); #1;
    end
    acc = cyc;
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL write_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
    end else if ({mem_we, mem_addr, mem_data} !== {1'b1, a, d}) begin
      n_fail++;
      $display("FAIL write_port: got we=%b addr=%h data=%h, required we=1 addr=%h data=%h",
               mem_we, mem_addr, mem_data, a, d);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [7:0] len, output int acc);
    int t = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_len = len;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 200) break;
      @(posedge clk); #1;
    end
    acc = cyc;
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL read_accept_timeout: cmd_ready=%b, required 1", cmd_ready);
    end else
      for (int i = 0; i <= int'(len); i++) begin
        logic [11:0] ai;
        ai = a + 12'(i);
        exp_q.push_back({i == int'(len), ref_mem[ai]});
      end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL %s_drain: pending=%0d busy=%b, required 0 and 0", nm, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_last, mem_re, mem_we, busy} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready,vld,last,re,we,busy=%b, required 000000",
               {cmd_ready, rsp_valid, rsp_last, mem_re, mem_we, busy});
    end
    n_checks++;
    if ({mem_addr, mem_data, rsp_data} !== 76'b0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h data=%h rsp=%h, required all 0", mem_addr, mem_data, rsp_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int acc;
    for (int i = 0; i < 4; i++) do_write(12'h010 + 12'(i), 32'hA5A5_0001 + 32'(i), acc);
    clear_logs();
    rsp_ready = 1'b1;
    do_read(12'h010, 8'd3, acc);
    drain("basic");
    n_checks++;
    if (beat_cyc.size() != 4 || re_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: beats=%0d issues=%0d, required 4 and 4", beat_cyc.size(), re_cyc.size());
    end else begin
      n_checks++;
      if (beat_cyc[0] - re_cyc[0] != 2) begin
        n_fail++;
        $display("FAIL basic_latency: %0d cycles, required 2", beat_cyc[0] - re_cyc[0]);
      end
      n_checks++;
      if (beat_cyc[3] - beat_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL basic_throughput: span=%0d, required 3", beat_cyc[3] - beat_cyc[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_logs();
    rsp_ready = 1'b1;
    do_read(12'h010, 8'd3, acc);
    for (int k = 0; k < 200 && (exp_q.size() != 0 || busy); k++) begin
      rsp_ready = pat[k % 4];
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    drain("bp");
    n_checks++;
    if (beat_cyc.size() != 4 || re_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL bp_count: beats=%0d issues=%0d, required 4 and 4", beat_cyc.size(), re_cyc.size());
    end else begin
      n_checks++;
      if (re_cyc[3] - re_cyc[0] <= 3) begin
        n_fail++;
        $display("FAIL bp_stall: issue span=%0d, required > 3", re_cyc[3] - re_cyc[0]);
      end
    end
  endtask

  task automatic test_wrap();
    int acc;
    logic [11:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 12'hFFE + 12'(i);
      do_write(a, 32'h0BAD_0000 + 32'(i) * 32'h11, acc);
    end
    clear_logs();
    rsp_ready = 1'b1;
    do_read(12'hFFE, 8'd3, acc);
    drain("wrap");
    n_checks++;
    if (re_addrs.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_count: issues=%0d, required 4", re_addrs.size());
    end else begin
      n_checks++;
      if (re_addrs[0] != 'hFFE || re_addrs[1] != 'hFFF || re_addrs[2] != 0 || re_addrs[3] != 1) begin
        n_fail++;
        $display("FAIL wrap_addr: %h %h %h %h, required ffe fff 000 001",
                 re_addrs[0], re_addrs[1], re_addrs[2], re_addrs[3]);
      end
      n_checks++;
      if (re_cyc[3] - re_cyc[0] != 3) begin
        n_fail++;
        $display("FAIL wrap_pause: issue span=%0d, required 3", re_cyc[3] - re_cyc[0]);
      end
    end
  endtask

  task automatic test_len0();
    int acc;
    clear_logs();
    rsp_ready = 1'b1;
    do_read(12'h011, 8'd0, acc);
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== (d == 3)) begin
        n_fail++;
        $display("FAIL len0_ready_at_%0d: cmd_ready=%b, required %b", d, cmd_ready, d == 3);
      end
    end
    @(posedge clk); #1;
    drain("len0");
    n_checks++;
    if (beat_cyc.size() != 1) begin
      n_fail++;
      $display("FAIL len0_count: beats=%0d, required 1", beat_cyc.size());
    end
  endtask

  task automatic test_write_during_burst();
    int acc, w;
    clear_logs();
    rsp_ready = 1'b1;
    do_read(12'h010, 8'd3, acc);
    do_write(12'h020, 32'hC0FF_EE01, w);
    n_checks++;
    if (re_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL wdb_issues: issues before write=%0d, required 4", re_cyc.size());
    end else begin
      n_checks++;
      if (w != re_cyc[3] + 2) begin
        n_fail++;
        $display("FAIL wdb_accept: write at +%0d after last issue, required +2", w - re_cyc[3]);
      end
    end
    drain("wdb");
    do_read(12'h020, 8'd0, acc);
    drain("wdb_readback");
  endtask

  task automatic test_reset_mid_burst();
    int acc;
    clear_logs();
    rsp_ready = 1'b0;
    do_read(12'h010, 8'd3, acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmb_buffered: rsp_valid=%b, required 1", rsp_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, busy, mem_re} !== 3'b000) begin
      n_fail++;
      $display("FAIL rmb_async_drop: vld,busy,re=%b, required 000", {rsp_valid, busy, mem_re});
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rmb_stale_%0d: rsp_valid=%b, required 0", i, rsp_valid);
      end
    end
    @(posedge clk); #1;
    do_read(12'h012, 8'd1, acc);
    drain("rmb_new_read");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_wrap();
    test_len0();
    test_write_during_burst();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
